// File: rtl/exa_vc_link_tx_if.sv
// Handshake bundle for exa_vc_link_tx: per-VC AXI-Stream sources in, one ExaNet flit link out.
interface exa_vc_link_tx_if #(
    parameter int NVC        = 6,
    parameter int DATA_WIDTH = 128
);
    logic [NVC*DATA_WIDTH-1:0] s_tdata;
    logic [NVC-1:0]            s_tvalid;
    logic [NVC-1:0]            s_tlast;
    logic [NVC-1:0]            s_tready;
    logic [DATA_WIDTH-1:0]     o_data;
    logic                      o_header_valid;
    logic                      o_payload_valid;
    logic                      o_footer_valid;
    logic                      i_header_ready;
    logic                      i_payload_ready;
    logic                      i_footer_ready;

    modport master (
        input  s_tdata, s_tvalid, s_tlast,
        input  i_header_ready, i_payload_ready, i_footer_ready,
        output s_tready, o_data, o_header_valid, o_payload_valid, o_footer_valid
    );

    modport slave (
        output s_tdata, s_tvalid, s_tlast,
        output i_header_ready, i_payload_ready, i_footer_ready,
        input  s_tready, o_data, o_header_valid, o_payload_valid, o_footer_valid
    );
endinterface

// File: rtl/exa_vc_link_tx.sv
// ExaNet link transmitter: strict-priority / per-priority round-robin arbitration over
// credit-gated VC sources, sending whole packets as header/payload/footer flits.
//
// state | meaning
// IDLE  | no packet in flight; arbitrate eligible VCs, grant consumes one credit
// HDR   | present header flit of the granted VC
// BODY  | present payload flits, then the footer (flit carrying tlast)
module exa_vc_link_tx #(
    parameter int prio_num   = 2,
    parameter int vc_num     = 3,
    parameter int DATA_WIDTH = 128,
    parameter int credit_max = 40,
    localparam int NVC       = prio_num * vc_num,
    localparam int logVcPrio = (NVC > 1) ? $clog2(NVC) : 1,
    localparam int CW        = $clog2(credit_max + 1)
) (
    input  logic                   ACLK,
    input  logic                   ARESETN,
    exa_vc_link_tx_if.master       link,
    input  logic [NVC-1:0]         i_credit_return,
    output logic [logVcPrio-1:0]   o_active_vc,
    output logic [NVC*CW-1:0]      o_credits,
    output logic [NVC-1:0]         o_credit_overflow,
    output logic                   o_proto_err
);
    localparam int PW = (prio_num > 1) ? $clog2(prio_num) : 1;
    localparam int VW = (vc_num > 1) ? $clog2(vc_num) : 1;

    typedef enum logic [1:0] {IDLE, HDR, BODY} state_t;

    state_t                state_q, state_d;
    logic [logVcPrio-1:0]  active_q;
    logic [PW-1:0]         prio_q;
    logic [VW-1:0]         vc_q;
    logic [VW-1:0]         rr_q [prio_num];
    logic [CW-1:0]         credit_q [NVC];
    logic [NVC-1:0]        ovf_q;
    logic                  perr_q;

    logic [NVC-1:0]        eligible;
    logic                  grant_ok;
    logic [PW-1:0]         grant_prio;
    logic [VW-1:0]         grant_vc;
    logic [logVcPrio-1:0]  grant_idx;
    logic [NVC-1:0]        grant_vec;

    logic                  act_valid, act_last;
    logic [DATA_WIDTH-1:0] act_data;
    logic [NVC-1:0]        act_onehot;

    logic                  hdr_v, pay_v, ftr_v;
    logic [NVC-1:0]        tready;
    logic [DATA_WIDTH-1:0] data_o;
    logic                  perr_set, ftr_done;

    always_comb begin
        for (int v = 0; v < NVC; v++) begin
            eligible[v] = link.s_tvalid[v] & (credit_q[v] != '0);
        end
    end

    // Later (higher) priorities overwrite earlier ones; inside a priority the
    // descending scan leaves the first eligible VC at/after the pointer.
    always_comb begin
        grant_ok   = 1'b0;
        grant_prio = '0;
        grant_vc   = '0;
        for (int p = 0; p < prio_num; p++) begin
            for (int k = vc_num - 1; k >= 0; k--) begin
                int c;
                c = int'(rr_q[p]) + k;
                if (c >= vc_num) c = c - vc_num;
                if (eligible[p*vc_num + c]) begin
                    grant_ok   = 1'b1;
                    grant_prio = PW'(p);
                    grant_vc   = VW'(c);
                end
            end
        end
    end

    assign grant_idx  = logVcPrio'(int'(grant_prio) * vc_num + int'(grant_vc));
    assign grant_vec  = (state_q == IDLE && grant_ok) ? (NVC'(1) << grant_idx) : '0;

    assign act_valid  = link.s_tvalid[active_q];
    assign act_last   = link.s_tlast[active_q];
    assign act_data   = link.s_tdata[int'(active_q)*DATA_WIDTH +: DATA_WIDTH];
    assign act_onehot = NVC'(1) << active_q;

    always_comb begin
        state_d  = state_q;
        hdr_v    = 1'b0;
        pay_v    = 1'b0;
        ftr_v    = 1'b0;
        tready   = '0;
        data_o   = '0;
        perr_set = 1'b0;
        ftr_done = 1'b0;
        case (state_q)
            IDLE: begin
                if (grant_ok) state_d = HDR;
            end
            HDR: begin
                data_o = act_data;
                hdr_v  = act_valid;
                if (act_valid && link.i_header_ready) begin
                    tready = act_onehot;
                    if (act_last) begin
                        perr_set = 1'b1;
                        state_d  = IDLE;
                    end else begin
                        state_d  = BODY;
                    end
                end
            end
            BODY: begin
                data_o = act_data;
                if (act_last) begin
                    ftr_v = act_valid;
                    if (act_valid && link.i_footer_ready) begin
                        tready   = act_onehot;
                        ftr_done = 1'b1;
                        state_d  = IDLE;
                    end
                end else begin
                    pay_v = act_valid;
                    if (act_valid && link.i_payload_ready) tready = act_onehot;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state_q  <= IDLE;
            active_q <= '0;
            prio_q   <= '0;
            vc_q     <= '0;
            rr_q     <= '{default: '0};
            credit_q <= '{default: CW'(credit_max)};
            ovf_q    <= '0;
            perr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && grant_ok) begin
                active_q <= grant_idx;
                prio_q   <= grant_prio;
                vc_q     <= grant_vc;
            end
            if (perr_set) perr_q <= 1'b1;
            if (ftr_done) rr_q[prio_q] <= (vc_q == VW'(vc_num - 1)) ? '0 : vc_q + 1'b1;
            // Grant and return on the same VC in one cycle cancel out.
            for (int v = 0; v < NVC; v++) begin
                case ({grant_vec[v], i_credit_return[v]})
                    2'b10: credit_q[v] <= credit_q[v] - 1'b1;
                    2'b01: begin
                        if (credit_q[v] == CW'(credit_max)) ovf_q[v]    <= 1'b1;
                        else                                credit_q[v] <= credit_q[v] + 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign link.o_data          = data_o;
    assign link.o_header_valid  = hdr_v;
    assign link.o_payload_valid = pay_v;
    assign link.o_footer_valid  = ftr_v;
    assign link.s_tready        = tready;

    for (genvar v = 0; v < NVC; v++) begin : g_credits
        assign o_credits[v*CW +: CW] = credit_q[v];
    end

    assign o_active_vc       = active_q;
    assign o_credit_overflow = ovf_q;
    assign o_proto_err       = perr_q;
endmodule

// File: tb/tb_exa_vc_link_tx.sv
// Bench for exa_vc_link_tx: queue-fed VC sources, transaction-level model checked every
// cycle, plus directed scenarios with literal cycle/credit expectations.
`timescale 1ns/1ps
module tb_exa_vc_link_tx;
    localparam int PRIO = 2;
    localparam int VCN  = 3;
    localparam int NVC  = PRIO * VCN;
    localparam int DW   = 128;
    localparam int CMAX = 40;
    localparam int AW   = 3;
    localparam int CW   = 6;
    localparam int K_H  = 0;
    localparam int K_P  = 1;
    localparam int K_F  = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    exa_vc_link_tx_if #(.NVC(NVC), .DATA_WIDTH(DW)) link ();
    logic [NVC-1:0]    credit_ret;
    logic [AW-1:0]     active_vc;
    logic [NVC*CW-1:0] credits;
    logic [NVC-1:0]    ovf;
    logic              perr;

    exa_vc_link_tx #(.prio_num(PRIO), .vc_num(VCN), .DATA_WIDTH(DW), .credit_max(CMAX)) dut (
        .ACLK              (clk),
        .ARESETN           (rst_n),
        .link              (link),
        .i_credit_return   (credit_ret),
        .o_active_vc       (active_vc),
        .o_credits         (credits),
        .o_credit_overflow (ovf),
        .o_proto_err       (perr)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int pid = 0;

    typedef struct { logic [DW-1:0] d; bit last; } flit_t;
    typedef struct { int cyc; int vc; int kind; } ev_t;
    flit_t srcq [NVC][$];
    ev_t   evlog[$];

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] mkdata(input int v, input int p, input int i);
        return {8'(v), 16'(p), 8'(i), 96'h5A5A_0000_1111_2222_3333_4444};
    endfunction

    task automatic push_pkt(input int v, input int n);
        flit_t f;
        for (int i = 0; i < n; i++) begin
            f.d    = mkdata(v, pid, i);
            f.last = (i == n - 1);
            srcq[v].push_back(f);
        end
        pid++;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int count_ev(input int vc, input int kind);
        int n = 0;
        foreach (evlog[i]) if (evlog[i].vc == vc && evlog[i].kind == kind) n++;
        return n;
    endfunction

    function automatic int find_ev(input int vc, input int kind, input int nth);
        int n = 0;
        foreach (evlog[i]) begin
            if (evlog[i].vc == vc && evlog[i].kind == kind) begin
                n++;
                if (n == nth) return evlog[i].cyc;
            end
        end
        return -1;
    endfunction

    task automatic wait_cnt(input int vc, input int kind, input int n, input int budget, input string name);
        int k = 0;
        while (count_ev(vc, kind) < n && k < budget) begin
            step();
            k++;
        end
        chk(name, DW'(count_ev(vc, kind) >= n), DW'(1));
    endtask

    // Source side: each VC presents the head of its queue; pops on an observed s_tready.
    initial begin
        logic [NVC-1:0] tr;
        link.s_tvalid = '0;
        link.s_tlast  = '0;
        link.s_tdata  = '0;
        forever begin
            @(negedge clk);
            tr = link.s_tready;
            @(posedge clk);
            #1;
            for (int v = 0; v < NVC; v++) if (tr[v] && srcq[v].size() > 0) void'(srcq[v].pop_front());
            #1;
            for (int v = 0; v < NVC; v++) begin
                if (srcq[v].size() > 0) begin
                    link.s_tvalid[v]           = 1'b1;
                    link.s_tlast[v]            = srcq[v][0].last;
                    link.s_tdata[v*DW +: DW]   = srcq[v][0].d;
                end else begin
                    link.s_tvalid[v]           = 1'b0;
                    link.s_tlast[v]            = 1'b0;
                    link.s_tdata[v*DW +: DW]   = '0;
                end
            end
        end
    end

    // Transaction model: link either idle (arbitrate) or streaming one packet of m_vc.
    bit m_busy, m_hdr, m_perr;
    int m_vc, m_active;
    int m_cred [NVC];
    bit m_ovf  [NVC];
    int m_rr   [PRIO];

    task automatic model_reset();
        m_busy = 0; m_hdr = 0; m_perr = 0; m_vc = 0; m_active = 0;
        for (int v = 0; v < NVC; v++) begin m_cred[v] = CMAX; m_ovf[v] = 0; end
        for (int p = 0; p < PRIO; p++) m_rr[p] = 0;
    endtask

    always @(negedge clk) begin : cmp
        bit eh, ep, ef, vld, rdy, found;
        logic [NVC-1:0] etr;
        logic [DW-1:0] ed;
        int kind, best, c, v;
        if (link.o_header_valid && link.i_header_ready)   evlog.push_back('{cyc, int'(active_vc), K_H});
        if (link.o_payload_valid && link.i_payload_ready) evlog.push_back('{cyc, int'(active_vc), K_P});
        if (link.o_footer_valid && link.i_footer_ready)   evlog.push_back('{cyc, int'(active_vc), K_F});
        if (!rst_n) begin
            model_reset();
            chk("rst_valids", DW'({link.o_header_valid, link.o_payload_valid, link.o_footer_valid}), '0);
            chk("rst_tready", DW'(link.s_tready), '0);
            chk("rst_data", link.o_data, '0);
            chk("rst_active", DW'(active_vc), '0);
            for (int i = 0; i < NVC; i++) chk("rst_credit", DW'(credits[i*CW +: CW]), DW'(CMAX));
            chk("rst_ovf", DW'(ovf), '0);
            chk("rst_perr", DW'(perr), '0);
        end else begin
            eh = 0; ep = 0; ef = 0; etr = '0; ed = '0; vld = 0; rdy = 0; kind = K_H; best = -1;
            if (m_busy) begin
                vld  = link.s_tvalid[m_vc];
                kind = m_hdr ? K_H : (link.s_tlast[m_vc] ? K_F : K_P);
                rdy  = (kind == K_H) ? link.i_header_ready :
                       (kind == K_P) ? link.i_payload_ready : link.i_footer_ready;
                eh = (kind == K_H) && vld;
                ep = (kind == K_P) && vld;
                ef = (kind == K_F) && vld;
                ed = link.s_tdata[m_vc*DW +: DW];
                if (vld && rdy) etr[m_vc] = 1'b1;
            end
            chk("hdr_valid", DW'(link.o_header_valid), DW'(eh));
            chk("pay_valid", DW'(link.o_payload_valid), DW'(ep));
            chk("ftr_valid", DW'(link.o_footer_valid), DW'(ef));
            chk("s_tready", DW'(link.s_tready), DW'(etr));
            if (eh || ep || ef) chk("o_data", link.o_data, ed);
            chk("active_vc", DW'(active_vc), DW'(m_active));
            for (int i = 0; i < NVC; i++) chk("credit", DW'(credits[i*CW +: CW]), DW'(m_cred[i]));
            for (int i = 0; i < NVC; i++) chk("overflow", DW'(ovf[i]), DW'(m_ovf[i]));
            chk("proto_err", DW'(perr), DW'(m_perr));

            if (m_busy) begin
                if (vld && rdy) begin
                    if (kind == K_H && link.s_tlast[m_vc]) begin
                        m_perr = 1; m_busy = 0;
                    end else if (kind == K_H) begin
                        m_hdr = 0;
                    end else if (kind == K_F) begin
                        m_busy = 0;
                        m_rr[m_vc / VCN] = (m_vc % VCN + 1) % VCN;
                    end
                end
            end else begin
                found = 0;
                for (int p = PRIO - 1; p >= 0; p--) begin
                    for (int d = 0; d < VCN; d++) begin
                        c = (m_rr[p] + d) % VCN;
                        v = p * VCN + c;
                        if (!found && link.s_tvalid[v] && m_cred[v] > 0) begin
                            found = 1;
                            best  = v;
                        end
                    end
                end
                if (found) begin m_busy = 1; m_hdr = 1; m_vc = best; m_active = best; end
            end
            for (int i = 0; i < NVC; i++) begin
                if (i == best && !credit_ret[i]) m_cred[i]--;
                else if (i != best && credit_ret[i]) begin
                    if (m_cred[i] == CMAX) m_ovf[i] = 1;
                    else m_cred[i]++;
                end
            end
        end
    end

    task automatic do_reset();
        rst_n = 1'b0;
        credit_ret = '0;
        link.i_header_ready  = 1'b1;
        link.i_payload_ready = 1'b1;
        link.i_footer_ready  = 1'b1;
        for (int v = 0; v < NVC; v++) srcq[v].delete();
        evlog.delete();
        repeat (3) step();
        rst_n = 1'b1;
        step();
    endtask

    initial begin : watchdog
        #300us;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int t0, p5;
        int hq[$];
        int exp3[6] = '{0, 1, 2, 0, 1, 2};
        credit_ret = '0;
        link.i_header_ready  = 1'b1;
        link.i_payload_ready = 1'b1;
        link.i_footer_ready  = 1'b1;

        // 1: single 4-flit packet on VC0
        do_reset();
        push_pkt(0, 4);
        t0 = cyc;
        wait_cnt(0, K_F, 1, 20, "t1_done");
        chk("t1_hdr_cyc", DW'(find_ev(0, K_H, 1)), DW'(t0 + 1));
        chk("t1_pay1_cyc", DW'(find_ev(0, K_P, 1)), DW'(t0 + 2));
        chk("t1_pay2_cyc", DW'(find_ev(0, K_P, 2)), DW'(t0 + 3));
        chk("t1_ftr_cyc", DW'(find_ev(0, K_F, 1)), DW'(t0 + 4));
        chk("t1_flits", DW'(evlog.size()), DW'(4));
        chk("t1_credit0", DW'(credits[0*CW +: CW]), DW'(39));

        // 2: priority 1 beats priority 0; loser granted right after the footer
        evlog.delete();
        push_pkt(1, 2);
        push_pkt(4, 2);
        t0 = cyc;
        wait_cnt(1, K_F, 1, 20, "t2_done");
        chk("t2_vc4_hdr", DW'(find_ev(4, K_H, 1)), DW'(t0 + 1));
        chk("t2_vc4_ftr", DW'(find_ev(4, K_F, 1)), DW'(t0 + 2));
        chk("t2_vc1_hdr", DW'(find_ev(1, K_H, 1)), DW'(t0 + 4));

        // 3: round robin inside priority 0
        do_reset();
        for (int r = 0; r < 2; r++) for (int v = 0; v < 3; v++) push_pkt(v, 2);
        wait_cnt(2, K_F, 2, 40, "t3_done");
        foreach (evlog[i]) if (evlog[i].kind == K_H) hq.push_back(evlog[i].vc);
        chk("t3_npkts", DW'(hq.size()), DW'(6));
        for (int i = 0; i < 6 && i < hq.size(); i++) chk("t3_order", DW'(hq[i]), DW'(exp3[i]));

        // 4: credit exhaustion on VC2, independence of VC3, resume on return
        do_reset();
        for (int i = 0; i < 41; i++) push_pkt(2, 2);
        wait_cnt(2, K_F, 40, 200, "t4_forty");
        repeat (5) step();
        chk("t4_vc2_held", DW'(count_ev(2, K_F)), DW'(40));
        chk("t4_credit2_zero", DW'(credits[2*CW +: CW]), DW'(0));
        chk("t4_vc2_pending", DW'(srcq[2].size()), DW'(2));
        push_pkt(3, 2);
        wait_cnt(3, K_F, 1, 20, "t4_vc3_sent");
        chk("t4_vc2_still", DW'(count_ev(2, K_F)), DW'(40));
        credit_ret[2] = 1'b1;
        step();
        credit_ret = '0;
        wait_cnt(2, K_F, 41, 20, "t4_vc2_resume");
        chk("t4_credit2_after", DW'(credits[2*CW +: CW]), DW'(0));
        push_pkt(3, 2);
        credit_ret[3] = 1'b1;
        step();
        credit_ret = '0;
        wait_cnt(3, K_F, 2, 20, "t4_vc3_second");
        chk("t4_credit3_same", DW'(credits[3*CW +: CW]), DW'(39));
        chk("t4_ovf3", DW'(ovf[3]), DW'(0));

        // 5: payload stall holds valid and data, no s_tready
        do_reset();
        link.i_payload_ready = 1'b0;
        p5 = pid;
        push_pkt(0, 4);
        wait_cnt(0, K_H, 1, 20, "t5_hdr");
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("t5_pay_held", DW'(link.o_payload_valid), DW'(1));
            chk("t5_data_stable", link.o_data, mkdata(0, p5, 1));
            chk("t5_no_tready", DW'(link.s_tready), '0);
            @(posedge clk);
            #1;
        end
        link.i_payload_ready = 1'b1;
        wait_cnt(0, K_F, 1, 20, "t5_done");
        chk("t5_payloads", DW'(count_ev(0, K_P)), DW'(2));

        // 6: header-only packet, overflow, reset mid-BODY
        do_reset();
        push_pkt(5, 1);
        push_pkt(5, 2);
        wait_cnt(5, K_H, 1, 20, "t6_hdr_only");
        chk("t6_proto_err", DW'(perr), DW'(1));
        @(negedge clk);
        chk("t6_idle_valids", DW'({link.o_header_valid, link.o_payload_valid, link.o_footer_valid}), '0);
        chk("t6_src_waiting", DW'(link.s_tvalid[5]), DW'(1));
        @(posedge clk);
        #1;
        wait_cnt(5, K_F, 1, 20, "t6_next_pkt");
        chk("t6_credit5", DW'(credits[5*CW +: CW]), DW'(38));
        credit_ret[0] = 1'b1;
        step();
        credit_ret = '0;
        chk("t6_ovf0", DW'(ovf[0]), DW'(1));
        chk("t6_credit0_sat", DW'(credits[0*CW +: CW]), DW'(40));
        link.i_payload_ready = 1'b0;
        push_pkt(1, 4);
        wait_cnt(1, K_H, 1, 20, "t6_body");
        @(negedge clk);
        chk("t6_in_body", DW'(link.o_payload_valid), DW'(1));
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("t6_rst_valids", DW'({link.o_header_valid, link.o_payload_valid, link.o_footer_valid}), '0);
        chk("t6_rst_tready", DW'(link.s_tready), '0);
        chk("t6_rst_credit1", DW'(credits[1*CW +: CW]), DW'(40));
        chk("t6_rst_credit5", DW'(credits[5*CW +: CW]), DW'(40));
        chk("t6_rst_flags", DW'({ovf, perr}), '0);
        for (int v = 0; v < NVC; v++) srcq[v].delete();
        link.i_payload_ready = 1'b1;
        repeat (2) step();
        rst_n = 1'b1;
        repeat (3) step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
